instr_fetch_unit: RTL and testbench

- Fetch stage sitting directly upstream of the 256x8 program ROM and downstream consumer of its data word.
- Holds the program counter, drives the ROM address, and latches the returned 8-bit instruction ({opcode[7:4], operand[3:0]}) into an instruction register for decode/execute.
- Resolves JMP and JC itself:
  - The 4-bit operand indexes a 16-entry jump-target table loaded by the control path.
  - A taken jump squashes the one instruction already fetched.

---
 rtl/instr_fetch_unit.sv | 87 ++++++++
 tb/tb_instr_fetch_unit.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Fetch stage: program counter, instruction register and JMP/JC resolution via a 16-entry target table.
// Optional macro FETCH_HALT_ON_FILL_EN: fetching ROM fill word 8'h0F halts fetch until reset.
module instr_fetch_unit #(
  parameter logic [7:0] RESET_VECTOR = 8'h00,
  parameter logic [3:0] OP_JMP       = 4'hE,
  parameter logic [3:0] OP_JC        = 4'hF
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [7:0] rom_addr,
  input  logic [7:0] rom_data,
  input  logic       stall,
  input  logic       carry_flag,
  input  logic       tbl_we,
  input  logic [3:0] tbl_idx,
  input  logic [7:0] tbl_addr,
  output logic [7:0] instr,
  output logic       instr_valid,
  output logic [7:0] instr_pc,
  output logic       jump_taken,
  output logic [7:0] pc
);

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_SQUASH = 2'd1;
`ifdef FETCH_HALT_ON_FILL_EN
  localparam logic [1:0] ST_HALT   = 2'd2;
`endif

  logic [1:0] state;
  logic [7:0] jtbl [16];
  logic       is_jump;
  logic       take;
  logic       advance;
  logic       fill;

  assign rom_addr = pc;
  assign is_jump  = (instr[7:4] == OP_JMP) || ((instr[7:4] == OP_JC) && carry_flag);
  // Jumps resolve only from RUN; the squash cycle never holds a live instruction.
  assign take     = (state == ST_RUN) && instr_valid && !stall && is_jump;

`ifdef FETCH_HALT_ON_FILL_EN
  assign advance  = !stall && (state != ST_HALT);
  assign fill     = (rom_data == 8'h0F);
`else
  assign advance  = !stall;
  assign fill     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc          <= RESET_VECTOR;
      instr       <= 8'h00;
      instr_valid <= 1'b0;
      instr_pc    <= 8'h00;
      jump_taken  <= 1'b0;
      state       <= ST_RUN;
      for (int i = 0; i < 16; i++) jtbl[i] <= 8'h00;
    end else begin
      // Table write lands at this edge; a same-cycle jump reads the old entry.
      if (tbl_we) jtbl[tbl_idx] <= tbl_addr;
      jump_taken <= 1'b0;
      if (advance) begin
        if (take) begin
          pc          <= jtbl[instr[3:0]];
          instr_valid <= 1'b0;
          jump_taken  <= 1'b1;
          state       <= ST_SQUASH;
        end else if (fill) begin
`ifdef FETCH_HALT_ON_FILL_EN
          instr       <= rom_data;
          instr_pc    <= pc;
          instr_valid <= 1'b0;
          state       <= ST_HALT;
`endif
        end else begin
          instr       <= rom_data;
          instr_pc    <= pc;
          instr_valid <= 1'b1;
          pc          <= pc + 8'd1;
          state       <= ST_RUN;
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: vector table, directed jump/stall/wrap/reset/halt sequences, random run vs model.
module tb_instr_fetch_unit;

`ifdef FETCH_HALT_ON_FILL_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rom_addr, rom_data;
  logic       stall = 1'b0, carry_flag = 1'b0, tbl_we = 1'b0;
  logic [3:0] tbl_idx = 4'h0;
  logic [7:0] tbl_addr = 8'h00;
  logic [7:0] instr, instr_pc, pc;
  logic       instr_valid, jump_taken;

  logic [7:0] rom [256];
  assign rom_data = rom[rom_addr];

  int nvec = 0;
  int nbad = 0;

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .rom_addr(rom_addr), .rom_data(rom_data),
    .stall(stall), .carry_flag(carry_flag), .tbl_we(tbl_we), .tbl_idx(tbl_idx),
    .tbl_addr(tbl_addr), .instr(instr), .instr_valid(instr_valid),
    .instr_pc(instr_pc), .jump_taken(jump_taken), .pc(pc)
  );

  typedef struct {
    logic       r, s, c, w;
    logic [3:0] i;
    logic [7:0] a;
    logic [7:0] epc, eipc, eins;
    logic       ev, ejt;
  } vec_t;

  vec_t tv [7];

  task automatic cyc(input logic r, input logic s, input logic c, input logic w,
                     input logic [3:0] i, input logic [7:0] a);
    @(negedge clk);
    rst_n = r; stall = s; carry_flag = c; tbl_we = w; tbl_idx = i; tbl_addr = a;
    @(posedge clk);
    #1;
  endtask

  task automatic run();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
  endtask

  task automatic chk(input string nm, input logic [7:0] p, input logic v,
                     input logic [7:0] ip, input logic [7:0] ins, input logic j);
    nvec++;
    if ({pc, rom_addr, instr_valid, instr_pc, instr, jump_taken} !== {p, p, v, ip, ins, j}) begin
      nbad++;
      $display("FAIL %s: got pc=%h addr=%h v=%b ipc=%h instr=%h jt=%b, want pc=%h v=%b ipc=%h instr=%h jt=%b",
               nm, pc, rom_addr, instr_valid, instr_pc, instr, jump_taken, p, v, ip, ins, j);
    end
  endtask

  // Reference model: architectural state only, stepped by the fetch rules.
  logic [7:0] m_pc, m_instr, m_ipc;
  logic [7:0] m_tbl [16];
  logic       m_v, m_jt, m_halt;

  task automatic model_step(input logic r, input logic s, input logic c, input logic w,
                            input logic [3:0] i, input logic [7:0] a);
    logic [7:0] word;
    logic [7:0] tgt;
    word = rom[m_pc];
    tgt  = m_tbl[m_instr[3:0]];
    if (!r) begin
      m_pc = 8'h00; m_instr = 8'h00; m_ipc = 8'h00; m_v = 1'b0; m_jt = 1'b0; m_halt = 1'b0;
      for (int k = 0; k < 16; k++) m_tbl[k] = 8'h00;
      return;
    end
    m_jt = 1'b0;
    if (!m_halt && !s) begin
      if (m_v && (m_instr[7:4] == 4'hE || (m_instr[7:4] == 4'hF && c))) begin
        m_pc = tgt; m_v = 1'b0; m_jt = 1'b1;
      end else if (HALT_EN && word == 8'h0F) begin
        m_instr = word; m_ipc = m_pc; m_v = 1'b0; m_halt = 1'b1;
      end else begin
        m_instr = word; m_ipc = m_pc; m_v = 1'b1; m_pc = m_pc + 8'd1;
      end
    end
    if (w) m_tbl[i] = a;
  endtask

  initial begin
    for (int k = 0; k < 256; k++) rom[k] = 8'h10;
    rom[0] = 8'h28; rom[1] = 8'h28; rom[2] = 8'h7A; rom[3] = 8'h50;

    // r s c w idx addr | pc ipc instr v jt
    tv[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
    tv[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 8'h01, 8'h00, 8'h28, 1'b1, 1'b0};
    tv[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 8'h02, 8'h01, 8'h28, 1'b1, 1'b0};
    tv[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 8'h03, 8'h02, 8'h7A, 1'b1, 1'b0};
    tv[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 8'h04, 8'h03, 8'h50, 1'b1, 1'b0};
    tv[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 4'h1, 8'h14, 8'h04, 8'h03, 8'h50, 1'b1, 1'b0};
    tv[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 8'h05, 8'h04, 8'h10, 1'b1, 1'b0};
    for (int k = 0; k < 7; k++) begin
      cyc(tv[k].r, tv[k].s, tv[k].c, tv[k].w, tv[k].i, tv[k].a);
      chk($sformatf("vec%0d", k), tv[k].epc, tv[k].ev, tv[k].eipc, tv[k].eins, tv[k].ejt);
    end

    // Program for the directed sequences.
    rom[8'h00] = 8'hE3; rom[8'h14] = 8'h22; rom[8'h17] = 8'hF2; rom[8'h18] = 8'hE1;
    rom[8'h19] = 8'h33; rom[8'h1A] = 8'hE1; rom[8'h30] = 8'hE4; rom[8'h35] = 8'h0F;

    // JMP through table
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00);  chk("jmp_rst",   8'h00, 1'b0, 8'h00, 8'h00, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 4'h3, 8'h18);  chk("jmp_f0",    8'h01, 1'b1, 8'h00, 8'hE3, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 4'h1, 8'h14);  chk("jmp_take",  8'h18, 1'b0, 8'h00, 8'hE3, 1'b1);
    run();                                      chk("jmp_sq",    8'h19, 1'b1, 8'h18, 8'hE1, 1'b0);
    run();                                      chk("jmp2_take", 8'h14, 1'b0, 8'h18, 8'hE1, 1'b1);
    run();                                      chk("jmp2_tgt",  8'h15, 1'b1, 8'h14, 8'h22, 1'b0);
    // JC not taken, then taken
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 4'h2, 8'h19);  chk("jc_f15",    8'h16, 1'b1, 8'h15, 8'h10, 1'b0);
    run();                                      chk("jc_f16",    8'h17, 1'b1, 8'h16, 8'h10, 1'b0);
    run();                                      chk("jc_f17",    8'h18, 1'b1, 8'h17, 8'hF2, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00);  chk("jc_nc",     8'h19, 1'b1, 8'h18, 8'hE1, 1'b0);
    run();                                      chk("jc_back",   8'h14, 1'b0, 8'h18, 8'hE1, 1'b1);
    run(); run(); run();                        chk("jc_f16b",   8'h17, 1'b1, 8'h16, 8'h10, 1'b0);
    run();                                      chk("jc_f17b",   8'h18, 1'b1, 8'h17, 8'hF2, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 8'h00);  chk("jc_take",   8'h19, 1'b0, 8'h17, 8'hF2, 1'b1);
    run();                                      chk("jc_tgt",    8'h1A, 1'b1, 8'h19, 8'h33, 1'b0);
    // Stalled JMP with table rewrite; same-index write on release uses old entry
    run();                                      chk("st_f",      8'h1B, 1'b1, 8'h1A, 8'hE1, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 4'h1, 8'h30);  chk("st_1",      8'h1B, 1'b1, 8'h1A, 8'hE1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 4'h4, 8'hFF);  chk("st_2",      8'h1B, 1'b1, 8'h1A, 8'hE1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 8'h00);  chk("st_3",      8'h1B, 1'b1, 8'h1A, 8'hE1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 4'h1, 8'h40);  chk("st_rel",    8'h30, 1'b0, 8'h1A, 8'hE1, 1'b1);
    // Jump to 8'hFF and wrap
    run();                                      chk("wr_f30",    8'h31, 1'b1, 8'h30, 8'hE4, 1'b0);
    run();                                      chk("wr_take",   8'hFF, 1'b0, 8'h30, 8'hE4, 1'b1);
    run();                                      chk("wr_wrap",   8'h00, 1'b1, 8'hFF, 8'h10, 1'b0);
    run();                                      chk("wr_f0",     8'h01, 1'b1, 8'h00, 8'hE3, 1'b0);
    run();                                      chk("sq_take",   8'h18, 1'b0, 8'h00, 8'hE3, 1'b1);
    // Reset during squash clears the table too
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 4'h3, 8'h77);  chk("sq_rst",    8'h00, 1'b0, 8'h00, 8'h00, 1'b0);
    run();                                      chk("clr_f0",    8'h01, 1'b1, 8'h00, 8'hE3, 1'b0);
    run();                                      chk("clr_take",  8'h00, 1'b0, 8'h00, 8'hE3, 1'b1);
    // Fill word at 8'h35
    rom[8'h00] = 8'hE5;
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 4'h5, 8'h35);  chk("fl_f0",     8'h01, 1'b1, 8'h00, 8'hE5, 1'b0);
    run();                                      chk("fl_take",   8'h35, 1'b0, 8'h00, 8'hE5, 1'b1);
    run();
    if (HALT_EN) chk("fl_halt", 8'h35, 1'b0, 8'h35, 8'h0F, 1'b0);
    else         chk("fl_nop",  8'h36, 1'b1, 8'h35, 8'h0F, 1'b0);
    run();
    if (HALT_EN) chk("fl_hold", 8'h35, 1'b0, 8'h35, 8'h0F, 1'b0);
    else         chk("fl_next", 8'h37, 1'b1, 8'h36, 8'h10, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 4'h5, 8'h00);
    if (HALT_EN) chk("fl_hold2", 8'h35, 1'b0, 8'h35, 8'h0F, 1'b0);
    else         chk("fl_stall", 8'h37, 1'b1, 8'h36, 8'h10, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00);  chk("fl_rst",    8'h00, 1'b0, 8'h00, 8'h00, 1'b0);

    // Random phase against the model; ROM biased toward jumps and fill words.
    for (int k = 0; k < 256; k++) begin
      case ($urandom_range(0, 9))
        0, 1:    rom[k] = {4'hE, 4'($urandom_range(0, 15))};
        2, 3:    rom[k] = {4'hF, 4'($urandom_range(0, 15))};
        4:       rom[k] = 8'h0F;
        default: rom[k] = 8'($urandom_range(0, 255));
      endcase
    end
    model_step(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
    chk("rnd_rst", m_pc, m_v, m_ipc, m_instr, m_jt);
    for (int n = 0; n < 600; n++) begin
      logic r, s, c, w;
      logic [3:0] i;
      logic [7:0] a;
      r = ($urandom_range(0, 39) != 0);
      s = ($urandom_range(0, 3) == 0);
      c = 1'($urandom_range(0, 1));
      w = ($urandom_range(0, 2) == 0);
      i = 4'($urandom_range(0, 15));
      a = 8'($urandom_range(0, 255));
      model_step(r, s, c, w, i, a);
      cyc(r, s, c, w, i, a);
      chk($sformatf("rnd%0d", n), m_pc, m_v, m_ipc, m_instr, m_jt);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
